seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter SHOW_CYCLES, default 50000, clock cycles each digit is driven.
REQ-003 Parameter BLANK_CYCLES, default 16, dead-time cycles between digits (anti-ghosting), >=1.
REQ-004 Port clk  input  1  single clock, rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port en  input  1  scan enable; low blanks the display.
REQ-007 Port load  input  1  one-cycle strobe capturing value.
REQ-008 Port value  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 least significant.
REQ-009 Port seg  output  7  segments a..g, active-high, bit 6 = a, bit 0 = g.
REQ-010 Port an  output  NUM_DIGITS  digit enables, one-hot or zero, active-high, bit k = digit k.
REQ-011 Port frame_done  output  1  one-cycle pulse at end of the last digit's SHOW slot.

Function
REQ-012 FSM states: BLANK (an=0, seg=0) and SHOW (an=one-hot current digit, seg=decoded nibble); seg, an and frame_done are registered outputs.
REQ-013 BLANK lasts exactly BLANK_CYCLES cycles, then -> SHOW for the same digit index.
REQ-014 SHOW lasts exactly SHOW_CYCLES cycles, then -> BLANK with digit index +1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 Frame period is NUM_DIGITS*(SHOW_CYCLES+BLANK_CYCLES) cycles; digits scan in order 0,1,...,NUM_DIGITS-1.
REQ-016 load writes value into a shadow register and sets pending; the display register is unchanged until commit.
REQ-017 Commit (display <= shadow, pending cleared) occurs on the SHOW->BLANK transition out of digit NUM_DIGITS-1, same cycle frame_done pulses; no tearing within a frame.
REQ-018 load coincident with commit: incoming value is committed directly, pending ends cleared.
REQ-019 load with pending already set overwrites the shadow; only the latest value is committed.
REQ-020 Decode: 0-F to standard hex glyphs (0=1111110, 1=0110000, 8=1111111, A=1110111, b=0011111, F=1000111).
REQ-021 en low: next cycle state BLANK, digit 0, cycle counter 0, an=0, seg=0, frame_done=0; if pending, commit immediately.
REQ-022 en rising: scan restarts at BLANK of digit 0 with a full BLANK_CYCLES interval.

Reset
REQ-023 rst_n low asynchronously forces seg=0, an=0, frame_done=0, state BLANK, digit 0, counter 0, shadow=0, display=0, pending=0.
REQ-024 Reset mid-frame abandons the frame; no commit, no frame_done pulse.
REQ-025 After rst_n rises with en high, first SHOW (digit 0, glyph "0") starts BLANK_CYCLES cycles later.

Configuration
REQ-026 Macro SEG_LEADING_ZERO_BLANK_EN defined: during SHOW of digit k>0, an stays 0 and seg=0 when display nibbles k..NUM_DIGITS-1 are all zero; digit 0 always shown; slot timing unchanged.
REQ-027 Macro undefined: every digit is shown, including leading zeros.

Structure
REQ-028 Shared package seg_pkg holds the FSM state enum, the 16-entry glyph constants and the blank-glyph constant.
REQ-029 Decoding is a separate sub-module hex_seg_dec (4-bit in, 7-bit out, combinational), instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1 unless noted)
REQ-030 Reset then en=1, load value=16'h1234 -> first frame shows 0000; next frame an=0001/seg=0110011, then 0010/1111001, 0100/1101101, 1000/0110000; each SHOW 4 cycles, BLANK 1 cycle; frame_done every 20 cycles.
REQ-031 load 16'hABCD mid-frame, then 16'hEF01 before frame end -> current frame unchanged; next frame shows EF01 only.
REQ-032 load asserted exactly on frame_done cycle with 16'h5555 -> next frame shows 5555; pending=0 afterwards.
REQ-033 en low for 3 cycles mid-SHOW of digit 2 -> an=0, seg=0 next cycle; on en high, BLANK 1 cycle then digit 0 SHOW.
REQ-034 With SEG_LEADING_ZERO_BLANK_EN, value 16'h0070 -> digits 3 blank, 1 shows 7, 0 shows 0; value 16'h0000 -> only digit 0 lit; without macro all four lit.
REQ-035 rst_n pulsed low mid-SHOW of digit 3 with pending set -> outputs 0 asynchronously; no frame_done; display 0000 after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Glyphs are ordered a..g with bit 6 = a and bit 0 = g, active-high.
package seg_pkg;

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } scan_state_e;

  localparam logic [6:0] SegBlank = 7'b000_0000;

  // Index 15 (F) is listed first so that SegGlyphs[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] SegGlyphs = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/hex_seg_dec.sv
// Combinational hex nibble to seven-segment glyph decoder.
module hex_seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup into the shared glyph constants.
  always_comb begin
    seg_o = SegGlyphs[nibble_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner with dead-time between digits and
// frame-synchronous (tear-free) value updates through a shadow register.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned MaxCycles = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles) > 0) ? $clog2(MaxCycles) : 1;
  localparam int unsigned DigW      = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [DigW-1:0] DigLast   = DigW'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [DigW-1:0]         digit_q, digit_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic       frame_end;
  logic       commit;
  logic [3:0] nibble;
  logic       lit;
  logic [6:0] glyph;

  // Scan FSM: BLANK/SHOW slot timing and digit sequencing; en low parks at digit 0.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q + 1'b1;
    frame_end = 1'b0;
    if (!en) begin
      state_d = StBlank;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (digit_q == DigLast) begin
              digit_d   = '0;
              frame_end = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = StBlank;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Shadow/display handoff; a load coincident with a commit bypasses the shadow.
  always_comb begin
    commit    = !en || frame_end;
    shadow_d  = load ? value : shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    if (commit) begin
      if (load) begin
        display_d = value;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Outputs are computed from next state so the registered outputs line up with it.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (DigW'(i) == digit_d) begin
        nibble = display_d[4*i +: 4];
      end
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is lit if it is digit 0 or any digit at or above it is non-zero.
    lit = (digit_d == '0);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if ((DigW'(i) >= digit_d) && (display_d[4*i +: 4] != 4'h0)) begin
        lit = 1'b1;
      end
    end
`else
    lit = 1'b1;
`endif
  end

  hex_seg_dec u_dec (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  // Registered output values for the upcoming cycle.
  always_comb begin
    seg_d = SegBlank;
    an_d  = '0;
    if (state_d == StShow && lit) begin
      seg_d          = glyph;
      an_d[digit_d]  = 1'b1;
    end
    frame_done_d = en && (state_d == StShow) && (digit_d == DigLast) && (cnt_d == ShowLast);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      digit_q      <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SegBlank;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1.
// Honours SEG_LEADING_ZERO_BLANK_EN for the leading-zero expectations.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GE = 7'b1001111;
  localparam logic [6:0] GF = 7'b1000111;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SHOW_CYCLES  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                     input logic fd_e);
    checks++;
    assert (an === an_e) else begin
      errors++;
      $error("FAIL %s an: got %b want %b", tag, an, an_e);
    end
    checks++;
    assert (seg === seg_e) else begin
      errors++;
      $error("FAIL %s seg: got %b want %b", tag, seg, seg_e);
    end
    checks++;
    assert (frame_done === fd_e) else begin
      errors++;
      $error("FAIL %s frame_done: got %b want %b", tag, frame_done, fd_e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    value = 16'h0000;
    tick(2);
    chk("reset", 4'b0000, 7'b0, 1'b0);

    // Release with en high; BLANK of digit 0 for one cycle.
    rst_n = 1'b1;
    en    = 1'b1;
    chk("first_blank", 4'b0000, 7'b0, 1'b0);
    load  = 1'b1;
    value = 16'h1234;
    tick(1);                                  // E1: SHOW d0
    load  = 1'b0;
    chk("f1_d0_start", 4'b0001, G0, 1'b0);
    tick(3);                                  // E4: SHOW d0 last cycle
    chk("f1_d0_end", 4'b0001, G0, 1'b0);
    tick(1);                                  // E5: BLANK d1
    chk("f1_blank_d1", 4'b0000, 7'b0, 1'b0);
    tick(1);                                  // E6: SHOW d1
    chk("f1_d1", 4'b0010, G0, 1'b0);
    tick(13);                                 // E19: last SHOW cycle of d3
    chk("f1_done", 4'b1000, G0, 1'b1);
    tick(1);                                  // E20: BLANK d0, commit
    chk("f2_blank_d0", 4'b0000, 7'b0, 1'b0);
    tick(1);                                  // E21
    chk("f2_d0", 4'b0001, G4, 1'b0);
    tick(5);                                  // E26
    chk("f2_d1", 4'b0010, G3, 1'b0);
    tick(5);                                  // E31
    chk("f2_d2", 4'b0100, G2, 1'b0);
    tick(5);                                  // E36
    chk("f2_d3", 4'b1000, G1, 1'b0);
    tick(3);                                  // E39
    chk("f2_done", 4'b1000, G1, 1'b1);

    // Two loads within a frame; only the latest appears, and only next frame.
    tick(2);                                  // E41: SHOW d0
    load  = 1'b1;
    value = 16'hABCD;
    tick(1);                                  // E42
    load  = 1'b0;
    tick(5);                                  // E47: SHOW d1
    chk("no_tear_d1", 4'b0010, G3, 1'b0);
    load  = 1'b1;
    value = 16'hEF01;
    tick(1);                                  // E48
    load  = 1'b0;
    tick(11);                                 // E59
    chk("no_tear_done", 4'b1000, G1, 1'b1);
    tick(2);                                  // E61
    chk("f4_d0", 4'b0001, G1, 1'b0);
    tick(5);                                  // E66
    chk("f4_d1", 4'b0010, G0, 1'b0);
    tick(5);                                  // E71
    chk("f4_d2", 4'b0100, GF, 1'b0);
    tick(5);                                  // E76
    chk("f4_d3", 4'b1000, GE, 1'b0);
    tick(3);                                  // E79: frame_done cycle
    chk("f4_done", 4'b1000, GE, 1'b1);

    // Load on the frame_done cycle commits straight into the next frame.
    load  = 1'b1;
    value = 16'h5555;
    tick(1);                                  // E80
    load  = 1'b0;
    tick(1);                                  // E81
    chk("direct_commit_d0", 4'b0001, G5, 1'b0);

    // en low mid-SHOW of digit 2 with a pending load: commits immediately.
    tick(10);                                 // E91: SHOW d2 cnt0
    load  = 1'b1;
    value = 16'h8888;
    tick(1);                                  // E92
    load  = 1'b0;
    chk("pre_disable_d2", 4'b0100, G5, 1'b0);
    en = 1'b0;
    tick(1);                                  // E93
    chk("disabled_1", 4'b0000, 7'b0, 1'b0);
    tick(2);                                  // E95
    chk("disabled_3", 4'b0000, 7'b0, 1'b0);
    en = 1'b1;
    chk("reenable_blank", 4'b0000, 7'b0, 1'b0);
    tick(1);                                  // E96: SHOW d0
    chk("reenable_d0", 4'b0001, G8, 1'b0);

    // Leading-zero behaviour with 0070.
    load  = 1'b1;
    value = 16'h0070;
    tick(1);                                  // E97
    load  = 1'b0;
    tick(17);                                 // E114
    chk("lz_done", 4'b1000, G8, 1'b1);
    tick(2);                                  // E116
    chk("lz_d0", 4'b0001, G0, 1'b0);
    tick(5);                                  // E121
    chk("lz_d1", 4'b0010, G7, 1'b0);
    tick(5);                                  // E126
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("lz_d2", 4'b0000, 7'b0, 1'b0);
`else
    chk("lz_d2", 4'b0100, G0, 1'b0);
`endif
    tick(5);                                  // E131: SHOW d3 cnt0
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("lz_d3", 4'b0000, 7'b0, 1'b0);
`else
    chk("lz_d3", 4'b1000, G0, 1'b0);
`endif

    // Asynchronous reset mid-SHOW of digit 3 with a pending load.
    load  = 1'b1;
    value = 16'h1111;
    tick(1);                                  // E132
    load  = 1'b0;
    tick(1);                                  // E133
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 7'b0, 1'b0);
    tick(2);
    chk("reset_hold", 4'b0000, 7'b0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_d0", 4'b0001, G0, 1'b0);
    tick(5);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("post_rst_d1", 4'b0000, 7'b0, 1'b0);
`else
    chk("post_rst_d1", 4'b0010, G0, 1'b0);
`endif
    tick(13);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("post_rst_done", 4'b0000, 7'b0, 1'b1);
`else
    chk("post_rst_done", 4'b1000, G0, 1'b1);
`endif
    tick(2);
    chk("post_rst_f2_d0", 4'b0001, G0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
